// File: rtl/keypad_calc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : keypad_calc_sequencer
// Purpose  : Turns the keypad scanner's key_pulse/key_code stream into a
//            two-operand add transaction. Collects up to DIGITS decimal digits
//            for operand A (committed with 'A') and operand B (committed with
//            '#'). Each operand is converted BCD->binary. A start/done
//            handshake then runs with the arithmetic unit, and the sum is held
//            for display.
// Ports    : clk, rst_n (sync, active low)
//            key_pulse, key_code[3:0]       - scanner event stream
//            alu_done, alu_result[OPW:0]    - arithmetic unit response
//            op_a, op_b [OPW-1:0]           - committed binary operands
//            alu_start                      - one-cycle start strobe
//            entry_bcd[4*DIGITS-1:0], entry_len[2:0] - digits being typed
//            result[OPW:0], result_valid    - latched sum, valid in SHOW
//            phase[2:0]                     - 0..5 = ENTER_A..ERROR
//            err_overflow (sticky), err_timeout (ERROR phase)
// Options  : define KEYPAD_BACKSPACE_EN to make 'B' delete the last digit.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_calc_sequencer #(
  parameter int DIGITS         = 3,
  parameter int OPW            = 10,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                key_pulse,
  input  logic [3:0]          key_code,
  input  logic                alu_done,
  input  logic [OPW:0]        alu_result,
  output logic [OPW-1:0]      op_a,
  output logic [OPW-1:0]      op_b,
  output logic                alu_start,
  output logic [4*DIGITS-1:0] entry_bcd,
  output logic [2:0]          entry_len,
  output logic [OPW:0]        result,
  output logic                result_valid,
  output logic [2:0]          phase,
  output logic                err_overflow,
  output logic                err_timeout
);

  localparam int EW = 4 * DIGITS;
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [3:0] KEY_A    = 4'd3;
  localparam logic [3:0] KEY_STAR = 4'd12;
  localparam logic [3:0] KEY_HASH = 4'd14;
`ifdef KEYPAD_BACKSPACE_EN
  localparam logic [3:0] KEY_B    = 4'd7;
`endif

  typedef enum logic [2:0] {
    ST_ENTER_A   = 3'd0,
    ST_ENTER_B   = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_SHOW      = 3'd4,
    ST_ERROR     = 3'd5
  } state_t;

  state_t          r_state, w_state;
  logic [OPW-1:0]  r_op_a, w_op_a;
  logic [OPW-1:0]  r_op_b, w_op_b;
  logic [EW-1:0]   r_entry, w_entry;
  logic [2:0]      r_len, w_len;
  logic [OPW:0]    r_result, w_result;
  logic            r_ovf, w_ovf;
  logic [CW-1:0]   r_cnt, w_cnt;

  logic            w_is_digit;
  logic [3:0]      w_digit;
  logic            w_clear;

  // Horner evaluation, most significant nibble first; truncated to OPW.
  function automatic logic [OPW-1:0] bcd_to_bin(input logic [EW-1:0] bcd);
    logic [31:0] acc;
    acc = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      acc = acc * 32'd10 + {28'd0, bcd[4*i +: 4]};
    end
    return acc[OPW-1:0];
  endfunction

  // Keypad layout: the digit keys are not contiguous in code space.
  always_comb begin
    w_is_digit = 1'b1;
    w_digit    = 4'd0;
    case (key_code)
      4'd0:    w_digit = 4'd1;
      4'd1:    w_digit = 4'd2;
      4'd2:    w_digit = 4'd3;
      4'd4:    w_digit = 4'd4;
      4'd5:    w_digit = 4'd5;
      4'd6:    w_digit = 4'd6;
      4'd8:    w_digit = 4'd7;
      4'd9:    w_digit = 4'd8;
      4'd10:   w_digit = 4'd9;
      4'd13:   w_digit = 4'd0;
      default: w_is_digit = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_ENTER_A;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_entry  <= '0;
      r_len    <= '0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state;
      r_op_a   <= w_op_a;
      r_op_b   <= w_op_b;
      r_entry  <= w_entry;
      r_len    <= w_len;
      r_result <= w_result;
      r_ovf    <= w_ovf;
      r_cnt    <= w_cnt;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_op_a   = r_op_a;
    w_op_b   = r_op_b;
    w_entry  = r_entry;
    w_len    = r_len;
    w_result = r_result;
    w_ovf    = r_ovf;
    w_cnt    = r_cnt;
    w_clear  = 1'b0;

    case (r_state)
      ST_ENTER_A, ST_ENTER_B: begin
        if (key_pulse) begin
          if (w_is_digit) begin
            if (r_len < 3'(DIGITS)) begin
              w_entry = (r_entry << 4) | EW'(w_digit);
              w_len   = r_len + 3'd1;
            end else begin
              w_ovf = 1'b1;
            end
          end else if (key_code == KEY_STAR) begin
            w_clear = 1'b1;
          end else if (key_code == KEY_A && r_state == ST_ENTER_A) begin
            w_op_a  = bcd_to_bin(r_entry);
            w_entry = '0;
            w_len   = '0;
            w_state = ST_ENTER_B;
          end else if (key_code == KEY_HASH && r_state == ST_ENTER_B) begin
            w_op_b  = bcd_to_bin(r_entry);
            w_entry = '0;
            w_len   = '0;
            w_state = ST_START;
          end
`ifdef KEYPAD_BACKSPACE_EN
          else if (key_code == KEY_B && r_len != 3'd0) begin
            w_entry = r_entry >> 4;
            w_len   = r_len - 3'd1;
            w_ovf   = 1'b0;
          end
`endif
        end
      end

      ST_START: begin
        w_cnt   = '0;
        w_state = ST_WAIT_DONE;
      end

      // Keys are dropped here; done takes priority over the timeout check.
      ST_WAIT_DONE: begin
        if (alu_done) begin
          w_result = alu_result;
          w_state  = ST_SHOW;
        end else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          w_state = ST_ERROR;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end

      // A digit starts a fresh calculation with that digit already entered.
      ST_SHOW: begin
        if (key_pulse) begin
          if (w_is_digit) begin
            w_op_a   = '0;
            w_op_b   = '0;
            w_result = '0;
            w_entry  = EW'(w_digit);
            w_len    = 3'd1;
            w_state  = ST_ENTER_A;
          end else if (key_code == KEY_STAR) begin
            w_clear = 1'b1;
          end
        end
      end

      ST_ERROR: begin
        if (key_pulse && key_code == KEY_STAR) begin
          w_clear = 1'b1;
        end
      end

      default: w_state = ST_ENTER_A;
    endcase

    if (w_clear) begin
      w_op_a   = '0;
      w_op_b   = '0;
      w_entry  = '0;
      w_len    = '0;
      w_result = '0;
      w_ovf    = 1'b0;
      w_state  = ST_ENTER_A;
    end
  end

  assign op_a         = r_op_a;
  assign op_b         = r_op_b;
  assign entry_bcd    = r_entry;
  assign entry_len    = r_len;
  assign result       = r_result;
  assign err_overflow = r_ovf;
  assign phase        = r_state;
  assign alu_start    = (r_state == ST_START);
  assign result_valid = (r_state == ST_SHOW);
  assign err_timeout  = (r_state == ST_ERROR);

endmodule
`default_nettype wire

// File: tb/tb_keypad_calc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_calc_sequencer
// Purpose  : Directed self-checking bench for keypad_calc_sequencer with
//            hand-computed expected values (DIGITS=3, OPW=10, short timeout).
//            Expectations for 'B' follow KEYPAD_BACKSPACE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_calc_sequencer;

  localparam int DIGITS = 3;
  localparam int OPW    = 10;
  localparam int TO     = 20;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                key_pulse;
  logic [3:0]          key_code;
  logic                alu_done;
  logic [OPW:0]        alu_result;
  logic [OPW-1:0]      op_a, op_b;
  logic                alu_start;
  logic [4*DIGITS-1:0] entry_bcd;
  logic [2:0]          entry_len;
  logic [OPW:0]        result;
  logic                result_valid;
  logic [2:0]          phase;
  logic                err_overflow;
  logic                err_timeout;

  int n_checks = 0;
  int n_fail   = 0;
  int n_starts;

  keypad_calc_sequencer #(
    .DIGITS(DIGITS), .OPW(OPW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_pulse(key_pulse), .key_code(key_code),
    .alu_done(alu_done), .alu_result(alu_result), .op_a(op_a), .op_b(op_b),
    .alu_start(alu_start), .entry_bcd(entry_bcd), .entry_len(entry_len),
    .result(result), .result_valid(result_valid), .phase(phase),
    .err_overflow(err_overflow), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One key event; returns on the negedge after the capturing posedge.
  task automatic press(input logic [3:0] code);
    @(negedge clk);
    key_pulse = 1'b1;
    key_code  = code;
    @(negedge clk);
    key_pulse = 1'b0;
    key_code  = 4'd0;
  endtask

  initial begin
    rst_n = 1'b0; key_pulse = 1'b0; key_code = 4'd0;
    alu_done = 1'b0; alu_result = '0;
    repeat (2) @(negedge clk);
    check("rst_phase", 32'(phase), 0);
    check("rst_op_a", 32'(op_a), 0);
    check("rst_entry", 32'(entry_bcd), 0);
    check("rst_start", 32'(alu_start), 0);
    rst_n = 1'b1;

    // alu_done outside WAIT_DONE is ignored
    alu_done = 1'b1; alu_result = 11'd99;
    @(negedge clk);
    alu_done = 1'b0;
    check("done_idle_result", 32'(result), 0);
    check("done_idle_phase", 32'(phase), 0);

    // 123 + 45
    press(4'd0); press(4'd1); press(4'd2);
    check("a_entry", 32'(entry_bcd), 32'h123);
    check("a_len", 32'(entry_len), 3);
    press(4'd14);                      // '#' ignored in ENTER_A
    check("hash_in_a", 32'(phase), 0);
    press(4'd11);                      // 'C' ignored
    check("c_ignored", 32'(entry_bcd), 32'h123);
    press(4'd3);
    check("op_a", 32'(op_a), 123);
    check("phase_b", 32'(phase), 1);
    check("entry_cleared", 32'(entry_len), 0);
    press(4'd4); press(4'd5);
    check("b_entry", 32'(entry_bcd), 32'h045);
    press(4'd14);
    check("op_b", 32'(op_b), 45);
    check("phase_start", 32'(phase), 2);
    check("start_hi", 32'(alu_start), 1);
    @(negedge clk);
    check("phase_wait", 32'(phase), 3);
    check("start_lo", 32'(alu_start), 0);
    alu_done = 1'b1; alu_result = 11'd168;
    @(negedge clk);
    alu_done = 1'b0;
    check("result", 32'(result), 168);
    check("result_valid", 32'(result_valid), 1);
    check("phase_show", 32'(phase), 4);

    // overflow and full clear
    press(4'd12);
    check("show_clear_phase", 32'(phase), 0);
    check("show_clear_result", 32'(result), 0);
    press(4'd10); press(4'd10); press(4'd10); press(4'd8);
    check("ovf_entry", 32'(entry_bcd), 32'h999);
    check("ovf_len", 32'(entry_len), 3);
    check("ovf_flag", 32'(err_overflow), 1);
    press(4'd12);
    check("clr_entry", 32'(entry_bcd), 0);
    check("clr_ovf", 32'(err_overflow), 0);
    check("clr_phase", 32'(phase), 0);

    // empty operands, then timeout
    press(4'd3); press(4'd14);
    check("empty_op_a", 32'(op_a), 0);
    check("empty_op_b", 32'(op_b), 0);
    check("empty_start", 32'(alu_start), 1);
    repeat (TO) @(negedge clk);
    check("wait_before_to", 32'(phase), 3);
    @(negedge clk);
    check("to_phase", 32'(phase), 5);
    check("to_flag", 32'(err_timeout), 1);
    press(4'd0);                       // digits do not leave ERROR
    check("err_digit", 32'(phase), 5);
    press(4'd12);
    check("err_exit", 32'(phase), 0);
    check("err_flag_lo", 32'(err_timeout), 0);

    // done and '*' in the same cycle: done wins
    press(4'd3); press(4'd14);
    @(negedge clk);
    check("wait2", 32'(phase), 3);
    key_pulse = 1'b1; key_code = 4'd12;
    alu_done = 1'b1; alu_result = 11'd7;
    @(negedge clk);
    key_pulse = 1'b0; alu_done = 1'b0;
    check("race_phase", 32'(phase), 4);
    check("race_result", 32'(result), 7);
    press(4'd8);
    check("show_digit_phase", 32'(phase), 0);
    check("show_digit_entry", 32'(entry_bcd), 32'h007);
    check("show_digit_len", 32'(entry_len), 1);
    check("show_digit_valid", 32'(result_valid), 0);
    check("show_digit_result", 32'(result), 0);

    // reset in WAIT_DONE
    press(4'd12);
    press(4'd0); press(4'd3); press(4'd1); press(4'd14);
    check("pre_rst_op_b", 32'(op_b), 2);
    @(negedge clk);
    check("pre_rst_wait", 32'(phase), 3);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_phase", 32'(phase), 0);
    check("mid_rst_op_a", 32'(op_a), 0);
    check("mid_rst_op_b", 32'(op_b), 0);
    n_starts = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (alu_start) n_starts++;
    end
    check("mid_rst_no_start", 32'(n_starts), 0);

    // 'B' behaviour
    press(4'd4); press(4'd5); press(4'd7); press(4'd6);
`ifdef KEYPAD_BACKSPACE_EN
    check("bksp_entry", 32'(entry_bcd), 32'h046);
    check("bksp_len", 32'(entry_len), 2);
`else
    check("b_ign_entry", 32'(entry_bcd), 32'h456);
    check("b_ign_len", 32'(entry_len), 3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
